sdfm_channel_q: RTL
===================

# sdfm_channel_q

Parametrised successor of the sigma-delta channel. It samples one modulator bitstream on a selectable SDCLK edge and runs a sinc1/sinc2/sinc3 decimation filter with configurable ratio, shift and output saturation. Results go either to a single overwrite register or to a DEPTH-entry acknowledge FIFO with overflow flag. It sits between the pin synchronisers and the register/bus block, one instance per channel.

## Interface
Parameters:
- DEC_W, 8: width of reg_filtdec; decimation ratio R = reg_filtdec+1, 1..2^DEC_W
- DATA_W, 16: result width
- DEPTH, 4: FIFO entries, power of two, ≥2

Ports:
- SYSCLK  in  1  system clock, single clock domain
- SYSRST  in  1  synchronous, active-high reset
- DSDIN  in  1  modulator data, already synchronised to SYSCLK
- SDCLK  in  1  modulator clock, already synchronised to SYSCLK
- reg_filtdec  in  DEC_W  decimation ratio minus one
- reg_filtmode  in  2  0: sample on SDCLK rise; 1: sample on fall; 2,3: reserved, no sampling
- reg_filten  in  1  filter enable
- reg_filtask  in  1  0: overwrite mode; 1: FIFO/acknowledge mode
- reg_filtst  in  2  0: sinc1; 1: sinc2; 2,3: sinc3
- reg_filtsh  in  5  result right-shift
- filt_ack  in  1  pop FIFO head (ask mode)
- filt_ovf_clr  in  1  clear overflow flag
- filt_data_out  out  DATA_W  result (overwrite register or FIFO head)
- filt_data_update  out  1  one-cycle pulse per new result
- filt_data_valid  out  1  FIFO non-empty (ask mode only)
- filt_level  out  $clog2(DEPTH)+1  FIFO occupancy
- filt_ovf  out  1  sticky overflow

## Operation
- Edge detect: SDCLK registered every cycle. The active edge is a transition between the registered value and the current SDCLK. DSDIN is captured on the same SYSCLK edge. Mode 2/3: no samples.
- Input x = DSDIN as unsigned 0/1. Three integrators and three combs, ACC_W = 3·DEC_W+1 bits, all arithmetic modulo 2^ACC_W (wrap intended). Order N uses stages 1..N.
- Bit counter 0..reg_filtdec, advanced per sample. At the count reg_filtdec it wraps to 0 and the comb stage evaluates. Result = comb_N >> reg_filtsh, saturated to 2^DATA_W−1.
- Warm-up: the first N results after reg_filten rises (or after reset) are discarded (no update, no write).
- reg_filten=0: integrators, combs, bit counter and warm-up count held at 0. The output register and FIFO are retained.
- Ask=0: each result loads filt_data_out and pulses filt_data_update. FIFO is held empty, filt_data_valid=0, filt_level=0.
- Ask=1: each result pulses filt_data_update and is written to the FIFO. filt_data_out = head (first-word fall-through), filt_data_valid = level≠0.
  - filt_ack while valid pops the head. filt_ack while empty is ignored.
  - Write while full: result dropped, filt_ovf set. Write and pop in the same cycle while full: both succeed, no overflow.
  - filt_ovf_clr clears filt_ovf; set wins over clear in the same cycle.
- Ask 1→0 flushes the FIFO. filt_data_out then shows the overwrite register, which retains its last value.
- Changing reg_filtdec/filtst/filtsh while enabled is allowed. Results are undefined until N+1 windows complete; no lockup.

## Timing
- Reset values: filt_data_out=0, filt_data_update=0, filt_data_valid=0, filt_level=0, filt_ovf=0, all internal state 0.
- Let E be the cycle the active edge is detected and DSDIN captured. Integrators update at E+1.
- On the last bit of a window, the comb/shift/saturate register and filt_data_update are asserted at E+2, and the FIFO write happens at E+2. filt_data_valid/filt_level reflect the write from E+3.
- Pop: filt_ack sampled high at cycle P; new head and level from P+1.
- SDCLK edges closer than 3 SYSCLK cycles are unsupported.
- SYSRST mid-window discards the partial window and restarts warm-up.

## Test plan
- Sinc1, dec=3 (R=4), sh=0, mode 0, DSDIN=1: first window discarded, then filt_data_update every 4 rising edges with filt_data_out=4; pulse exactly E+2 after the 4th edge.
- Sinc1, R=4, DSDIN alternating 1,0 on falling edges (mode 1) → steady result 2; the same stimulus in mode 2 → no updates ever.
- Sinc3, R=4, all ones → 3 windows discarded, then 64. Sinc3, dec=255, all ones, sh=0 → 65535 (saturated); sh=9 → 32768.
- Ask=1, DEPTH=4, no ack, 5 results → level 4, ovf=1, 5th dropped. Ack ×4 returns results in order, valid falls after the 4th pop. Ovf_clr clears ovf. Write+ack while full → no ovf.
- SYSRST asserted mid-window with 2 entries queued → next cycle: all outputs 0. Re-enable → warm-up repeats before the first update.

Source files
------------

// File: rtl/sdfm_channel_q.sv
// Sigma-delta filter channel: SDCLK edge sampling, sinc1/2/3 decimation with shift and
// saturation, delivering results to an overwrite register or an acknowledge FIFO.
module sdfm_channel_q #(
  parameter int DEC_W  = 8,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic                     SYSCLK,
  input  logic                     SYSRST,
  input  logic                     DSDIN,
  input  logic                     SDCLK,
  input  logic [DEC_W-1:0]         reg_filtdec,
  input  logic [1:0]               reg_filtmode,
  input  logic                     reg_filten,
  input  logic                     reg_filtask,
  input  logic [1:0]               reg_filtst,
  input  logic [4:0]               reg_filtsh,
  input  logic                     filt_ack,
  input  logic                     filt_ovf_clr,
  output logic [DATA_W-1:0]        filt_data_out,
  output logic                     filt_data_update,
  output logic                     filt_data_valid,
  output logic [$clog2(DEPTH):0]   filt_level,
  output logic                     filt_ovf
);

  localparam int ACC_W = 3 * DEC_W + 1;
  localparam int AW    = $clog2(DEPTH);
  localparam int LW    = AW + 1;
  localparam int EXT_W = ACC_W + DATA_W;
  localparam logic [EXT_W-1:0] SAT_MAX = (EXT_W'(1) << DATA_W) - EXT_W'(1);

  logic                 sdclk_q, sdclk_d;
  logic [ACC_W-1:0]     i1_q, i1_d, i2_q, i2_d, i3_q, i3_d;
  logic [ACC_W-1:0]     d1_q, d1_d, d2_q, d2_d, d3_q, d3_d;
  logic [DEC_W-1:0]     cnt_q, cnt_d;
  logic                 last_q, last_d;
  logic [1:0]           warm_q, warm_d;
  logic [DATA_W-1:0]    res_q, res_d;
  logic                 upd_q, upd_d;
  logic [DATA_W-1:0]    ovw_q, ovw_d;
  logic [DATA_W-1:0]    mem_q [DEPTH];
  logic [DATA_W-1:0]    mem_d [DEPTH];
  logic [AW-1:0]        rd_q, rd_d, wr_q, wr_d;
  logic [LW-1:0]        level_q, level_d;
  logic                 ovf_q, ovf_d;

  logic                 sample;
  logic [1:0]           n_ord;
  logic [ACC_W-1:0]     x_ext, comb_in, c1, c2, c3, comb_out, shifted;
  logic [EXT_W-1:0]     shifted_ext;
  logic [DATA_W-1:0]    sat_val;
  logic                 full, empty, pop, push, ovf_set;

  always_comb begin
    sdclk_d = SDCLK;
    sample  = 1'b0;
    if (reg_filten) begin
      if (reg_filtmode == 2'd0)      sample = SDCLK & ~sdclk_q;
      else if (reg_filtmode == 2'd1) sample = ~SDCLK & sdclk_q;
    end

    n_ord    = (reg_filtst == 2'd0) ? 2'd1 : (reg_filtst == 2'd1) ? 2'd2 : 2'd3;
    x_ext    = {{(ACC_W-1){1'b0}}, DSDIN};
    comb_in  = (reg_filtst == 2'd0) ? i1_q : (reg_filtst == 2'd1) ? i2_q : i3_q;
    c1       = comb_in - d1_q;
    c2       = c1 - d2_q;
    c3       = c2 - d3_q;
    comb_out = (reg_filtst == 2'd0) ? c1 : (reg_filtst == 2'd1) ? c2 : c3;
    shifted  = comb_out >> reg_filtsh;
    shifted_ext = EXT_W'(shifted);
    sat_val  = (shifted_ext > SAT_MAX) ? {DATA_W{1'b1}} : shifted_ext[DATA_W-1:0];

    i1_d = i1_q;  i2_d = i2_q;  i3_d = i3_q;
    d1_d = d1_q;  d2_d = d2_q;  d3_d = d3_q;
    cnt_d  = cnt_q;
    last_d = 1'b0;
    warm_d = warm_q;
    res_d  = res_q;
    upd_d  = 1'b0;
    ovw_d  = ovw_q;

    if (!reg_filten) begin
      i1_d = '0;  i2_d = '0;  i3_d = '0;
      d1_d = '0;  d2_d = '0;  d3_d = '0;
      cnt_d  = '0;
      warm_d = '0;
    end else begin
      // Integrators use the previous stage's old value; steady-state gain is still R^N.
      if (sample) begin
        i1_d = i1_q + x_ext;
        i2_d = i2_q + i1_q;
        i3_d = i3_q + i2_q;
        if (cnt_q == reg_filtdec) begin
          cnt_d  = '0;
          last_d = 1'b1;
        end else begin
          cnt_d = cnt_q + DEC_W'(1);
        end
      end
      if (last_q) begin
        d1_d = comb_in;
        d2_d = c1;
        d3_d = c2;
        if (warm_q < n_ord) begin
          warm_d = warm_q + 2'd1;
        end else begin
          res_d = sat_val;
          upd_d = 1'b1;
          if (!reg_filtask) ovw_d = sat_val;
        end
      end
    end
  end

  always_comb begin
    mem_d   = mem_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    level_d = level_q;
    full    = (level_q == LW'(DEPTH));
    empty   = (level_q == '0);
    pop     = 1'b0;
    push    = 1'b0;
    ovf_set = 1'b0;
    if (!reg_filtask) begin
      rd_d    = '0;
      wr_d    = '0;
      level_d = '0;
    end else begin
      pop  = filt_ack & ~empty;
      // A pop in the same cycle frees the slot, so a full FIFO can still accept the write.
      push = upd_q & (~full | pop);
      ovf_set = upd_q & full & ~pop;
      if (push) begin
        mem_d[wr_q] = res_q;
        wr_d = wr_q + AW'(1);
      end
      if (pop) rd_d = rd_q + AW'(1);
      level_d = level_q + LW'(push) - LW'(pop);
    end
    ovf_d = ovf_set | (ovf_q & ~filt_ovf_clr);
  end

  always_ff @(posedge SYSCLK) begin
    if (SYSRST) begin
      sdclk_q <= 1'b0;
      i1_q    <= '0;  i2_q <= '0;  i3_q <= '0;
      d1_q    <= '0;  d2_q <= '0;  d3_q <= '0;
      cnt_q   <= '0;
      last_q  <= 1'b0;
      warm_q  <= '0;
      res_q   <= '0;
      upd_q   <= 1'b0;
      ovw_q   <= '0;
      mem_q   <= '{default: '0};
      rd_q    <= '0;
      wr_q    <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      sdclk_q <= sdclk_d;
      i1_q    <= i1_d;  i2_q <= i2_d;  i3_q <= i3_d;
      d1_q    <= d1_d;  d2_q <= d2_d;  d3_q <= d3_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      warm_q  <= warm_d;
      res_q   <= res_d;
      upd_q   <= upd_d;
      ovw_q   <= ovw_d;
      mem_q   <= mem_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
    end
  end

  assign filt_data_out    = reg_filtask ? mem_q[rd_q] : ovw_q;
  assign filt_data_update = upd_q;
  assign filt_data_valid  = reg_filtask & (level_q != '0);
  assign filt_level       = level_q;
  assign filt_ovf         = ovf_q;

endmodule
